// File: rtl/dec_lock_ctrl.sv
// rtl/dec_lock_ctrl.sv - two-lane sync-header block-lock controller for the decode datapath
//
// Hunts for block lock on both lanes by checking each block's sync header,
// requests per-lane bit slips from the upstream aligner on bad headers, and
// enables the decoder once lock is held. While locked, it counts bad blocks per
// window and drops lock when the window's error budget is used up.
//
// Ports:
//   enc_clk      in   decode clock
//   rst          in   asynchronous active-low reset
//   link_en      in   link enable; low forces IDLE
//   gen_speed    in   [1:0] 00=GEN4, 01=GEN3, 10=GEN2, 11=reserved
//   blk_valid    in   one-cycle strobe, new block on both lanes
//   lane_0_sync  in   [3:0] lane 0 sync header
//   lane_1_sync  in   [3:0] lane 1 sync header
//   enable_dec   out  decoder enable
//   block_lock   out  both lanes locked
//   slip_0       out  one-cycle bit-slip request, lane 0
//   slip_1       out  one-cycle bit-slip request, lane 1
//   lock_lost    out  one-cycle pulse when lock is dropped from LOCKED
//   err_cnt      out  [CW-1:0] bad blocks in the current window
module dec_lock_ctrl #(
  parameter int LOCK_CNT  = 64,
  parameter int WIN_LEN   = 1024,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 2,
  localparam int CW = $clog2(BAD_MAX + 1)
) (
  input  logic          enc_clk,
  input  logic          rst,
  input  logic          link_en,
  input  logic [1:0]    gen_speed,
  input  logic          blk_valid,
  input  logic [3:0]    lane_0_sync,
  input  logic [3:0]    lane_1_sync,
  output logic          enable_dec,
  output logic          block_lock,
  output logic          slip_0,
  output logic          slip_1,
  output logic          lock_lost,
  output logic [CW-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int HW = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SLIP_WAIT - 1);
  localparam logic [CW-1:0] ERR_LAST  = CW'(BAD_MAX - 1);
  localparam logic [CW-1:0] ERR_SAT   = CW'(BAD_MAX);

  localparam logic [1:0] SPD_GEN4 = 2'b00;
  localparam logic [1:0] SPD_GEN3 = 2'b01;
  localparam logic [1:0] SPD_GEN2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HUNT      = 2'd1,
    SLIP_HOLD = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gen_spd_q, gen_spd_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [WW-1:0]   win_cnt_q, win_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic            enable_dec_q, enable_dec_d;
  logic            block_lock_q, block_lock_d;
  logic            slip_0_q, slip_0_d;
  logic            slip_1_q, slip_1_d;
  logic            lock_lost_q, lock_lost_d;

  logic            lane_0_ok, lane_1_ok, blk_good;

  // Header rules use the registered speed; a speed change forces HUNT on the
  // same edge, so headers are never judged against a speed still in flux.
  function automatic logic hdr_ok(input logic [1:0] spd, input logic [3:0] sync);
    logic ok;
    ok = 1'b0;
    case (spd)
      SPD_GEN4: ok = 1'b1;
      SPD_GEN3: ok = (sync == 4'b0101) || (sync == 4'b1010);
      SPD_GEN2: ok = (sync[1:0] == 2'b01) || (sync[1:0] == 2'b10);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_comb begin
    lane_0_ok = hdr_ok(gen_spd_q, lane_0_sync);
    lane_1_ok = hdr_ok(gen_spd_q, lane_1_sync);
    blk_good  = lane_0_ok && lane_1_ok;
  end

  always_comb begin
    state_d     = state_q;
    gen_spd_d   = gen_speed;
    good_cnt_d  = good_cnt_q;
    win_cnt_d   = win_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    err_cnt_d   = err_cnt_q;
    slip_0_d    = 1'b0;
    slip_1_d    = 1'b0;
    lock_lost_d = 1'b0;

    if (!link_en) begin
      state_d    = IDLE;
      good_cnt_d = '0;
      win_cnt_d  = '0;
      hold_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (state_q != IDLE && gen_speed != gen_spd_q) begin
      state_d     = HUNT;
      good_cnt_d  = '0;
      win_cnt_d   = '0;
      hold_cnt_d  = '0;
      err_cnt_d   = '0;
      lock_lost_d = (state_q == LOCKED);
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;

        HUNT: begin
          if (blk_valid) begin
            if (blk_good) begin
              // GEN4 has no sync header to qualify, so lock is immediate.
              if (gen_spd_q == SPD_GEN4 || good_cnt_q == GOOD_LAST) begin
                state_d    = LOCKED;
                good_cnt_d = '0;
              end else begin
                good_cnt_d = good_cnt_q + GW'(1);
              end
            end else begin
              good_cnt_d = '0;
              hold_cnt_d = '0;
              slip_0_d   = !lane_0_ok;
              slip_1_d   = !lane_1_ok;
              state_d    = SLIP_HOLD;
            end
          end
        end

        // Give the aligner time to apply the slip before judging headers again.
        SLIP_HOLD: begin
          if (blk_valid) begin
            if (hold_cnt_q == HOLD_LAST) begin
              hold_cnt_d = '0;
              state_d    = HUNT;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end
        end

        LOCKED: begin
          if (blk_valid) begin
            // Loss of lock takes priority over the window rollover.
            if (!blk_good && err_cnt_q == ERR_LAST) begin
              state_d     = HUNT;
              lock_lost_d = 1'b1;
              good_cnt_d  = '0;
              win_cnt_d   = '0;
              hold_cnt_d  = '0;
              err_cnt_d   = '0;
            end else if (win_cnt_q == WIN_LAST) begin
              win_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + WW'(1);
              if (!blk_good && err_cnt_q != ERR_SAT) begin
                err_cnt_d = err_cnt_q + CW'(1);
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    enable_dec_d = (state_d == LOCKED);
    block_lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gen_spd_q    <= gen_speed;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      err_cnt_q    <= '0;
      enable_dec_q <= 1'b0;
      block_lock_q <= 1'b0;
      slip_0_q     <= 1'b0;
      slip_1_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gen_spd_q    <= gen_spd_d;
      good_cnt_q   <= good_cnt_d;
      win_cnt_q    <= win_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      err_cnt_q    <= err_cnt_d;
      enable_dec_q <= enable_dec_d;
      block_lock_q <= block_lock_d;
      slip_0_q     <= slip_0_d;
      slip_1_q     <= slip_1_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign enable_dec = enable_dec_q;
  assign block_lock = block_lock_q;
  assign slip_0     = slip_0_q;
  assign slip_1     = slip_1_q;
  assign lock_lost  = lock_lost_q;
  assign err_cnt    = err_cnt_q;

endmodule
